// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and bit-timing helpers
package uart_pkg;
    localparam int DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;
    function automatic int half_period(input int bit_period);
        return bit_period / 2;
    endfunction
endpackage

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 oversampling UART deserialiser with mid-bit start-glitch rejection
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CNT_WIDTH  = 16,
    parameter int BIT_PERIOD = 868
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 ok,
    output logic                 waiting
);
    localparam logic [CNT_WIDTH-1:0] HALF_M1 = CNT_WIDTH'(half_period(BIT_PERIOD) - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_M1 = CNT_WIDTH'(BIT_PERIOD - 1);
    uart_state_t          state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 half_tick, full_tick;
    logic [DATA_BITS-1:0] next_shreg;
    assign half_tick  = cnt == HALF_M1;
    assign full_tick  = cnt == FULL_M1;
    assign next_shreg = {uart_rx, shreg[DATA_BITS-1:1]};
    assign waiting    = state == IDLE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            data  <= '0;
            ok    <= 1'b0;
        end else begin
            ok  <= 1'b0;
            cnt <= cnt + CNT_WIDTH'(1);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!uart_rx) state <= START;
                end
                START: if (half_tick) begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= uart_rx ? IDLE : DATA;
                end
                DATA: if (full_tick) begin
                    cnt   <= '0;
                    shreg <= next_shreg;
                    idx   <= idx + 3'd1;
                    if (idx == 3'(DATA_BITS - 1)) begin
                        data  <= next_shreg;
                        ok    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: if (full_tick) begin
                    cnt   <= '0;
                    state <= uart_rx ? IDLE : BREAK;
                end
                BREAK: begin
                    // a held-low line must go high before any new start bit counts
                    cnt <= '0;
                    if (uart_rx) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver (BIT_PERIOD=8)
module tb_uart_receiver;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] data;
    logic       ok, waiting;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_byte = 8'h00;
    logic       prev_ok = 1'b0;

    always #5 clk = ~clk;

    uart_receiver #(.CNT_WIDTH(4), .BIT_PERIOD(8)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx),
        .data(data), .ok(ok), .waiting(waiting)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic b, input int n);
        uart_rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input int stop_len, input logic stop_val);
        exp_q.push_back(b);
        cyc(1'b0, 8);
        chk("start_waiting", {7'd0, waiting}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("data_hold", data, last_byte);
            cyc(b[i], 8);
        end
        last_byte = b;
        cyc(stop_val, stop_len);
    endtask

    initial forever begin
        @(negedge clk);
        if (ok) begin
            if (exp_q.size() == 0) chk("spurious_ok", {7'd0, ok}, 8'd0);
            else begin
                chk("ok_data", data, exp_q.pop_front());
                chk("ok_waiting", {7'd0, waiting}, 8'd0);
            end
            chk("ok_width", {7'd0, prev_ok}, 8'd0);
        end
        prev_ok = ok;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 10);
        chk("rst_waiting", {7'd0, waiting}, 8'd1);
        chk("rst_ok", {7'd0, ok}, 8'd0);
        chk("rst_data", data, 8'h00);
        cyc(1'b0, 1);
        chk("glitch_enter", {7'd0, waiting}, 8'd0);
        cyc(1'b1, 3);
        chk("glitch_mid", {7'd0, waiting}, 8'd0);
        cyc(1'b1, 1);
        chk("glitch_reject", {7'd0, waiting}, 8'd1);
        cyc(1'b1, 3);
        frame(8'hCD, 8, 1'b1);
        chk("cd_idle", {7'd0, waiting}, 8'd1);
        cyc(1'b1, 7);
        frame(8'h87, 8, 1'b1);
        chk("87_idle", {7'd0, waiting}, 8'd1);
        frame(8'hA5, 8, 1'b1);
        chk("a5_idle", {7'd0, waiting}, 8'd1);
        frame(8'h96, 20, 1'b0);
        chk("break_hold", {7'd0, waiting}, 8'd0);
        cyc(1'b1, 1);
        chk("break_exit", {7'd0, waiting}, 8'd1);
        cyc(1'b1, 5);
        cyc(1'b0, 8);
        cyc(1'b1, 8);
        cyc(1'b0, 8);
        cyc(1'b1, 4);
        reset = 1'b0;
        #1;
        chk("midrst_waiting", {7'd0, waiting}, 8'd1);
        chk("midrst_ok", {7'd0, ok}, 8'd0);
        chk("midrst_data", data, 8'h00);
        last_byte = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 4);
        frame(8'h5A, 8, 1'b1);
        chk("5a_idle", {7'd0, waiting}, 8'd1);
        cyc(1'b1, 4);
        chk("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
